pipe_mem_stage: RTL and testbench

//   MEM stage between the EX/MEM and MEM/WB pipeline registers. Runs loads and stores against a data memory

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_mem_stage_if.sv | 23 ++
 rtl/mem_align.sv | 45 ++++
 rtl/pipe_mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_mem_stage.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM pipeline stage: access sizes, FSM states,
// and the request/writeback bundles held while a memory access is in flight.
package pipe_pkg;

    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    // Writeback controls forwarded to MEM/WB; exe_out doubles as the byte address
    typedef struct packed {
        logic        mux_rf_dmem;
        logic        rf_wena;
        logic [4:0]  rf_waddr;
        logic        hi_ena;
        logic [31:0] hi_idata;
        logic        lo_ena;
        logic [31:0] lo_idata;
        logic [31:0] exe_out;
    } wb_ctrl_t;

    // Memory request captured when the access is accepted
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    // A half needs addr[0]=0, a word needs addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == MEM_SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: the master raises dmem_req with stable we/be/addr/wdata and holds
// them until a cycle in which dmem_ready is also high; that cycle completes the
// access (dmem_rdata valid for reads). dmem_ready without dmem_req is ignored.
interface pipe_mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// Little-endian byte-lane steering: byte enables and replicated store data
// from size/lane, and lane selection plus sign/zero extension for load data.
module mem_align
    import pipe_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sext,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane steering; anything other than byte/half is treated as a full word
    always_comb begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        byte_v    = 8'(rdata_in >> {lane, 3'b000});
        half_v    = 16'(rdata_in >> {lane[1], 4'b0000});
        case (size)
            MEM_SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{sext & byte_v[7]}}, byte_v};
            end
            MEM_SZ_HALF: begin
                be        = 4'b0011 << {lane[1], 1'b0};
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{sext & half_v[15]}}, half_v};
            end
            default: begin
                be        = 4'b1111;
                wdata_out = wdata_in;
                rdata_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM pipeline stage. Non-memory slots pass straight through; loads/stores are
// captured, stall the pipe, and run on the data-memory bus until ready or a
// timeout abort. Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word
// accesses trap instead of being aligned down).
module pipe_mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               mem_ren,
    input  logic               mem_wen,
    input  logic [1:0]         mem_size,
    input  logic               mem_sext,
    input  logic [31:0]        mem_wdata,
    input  logic [31:0]        exe_out,
    input  logic               mux_rf_DMEM,
    input  logic               rf_wena,
    input  logic [4:0]         rf_waddr,
    input  logic               hi_ena,
    input  logic [31:0]        hi_idata,
    input  logic               lo_ena,
    input  logic [31:0]        lo_idata,
    output logic               o_mux_rf_DMEM,
    output logic               o_rf_wena,
    output logic [4:0]         o_rf_waddr,
    output logic               o_hi_ena,
    output logic [31:0]        o_hi_idata,
    output logic               o_lo_ena,
    output logic [31:0]        o_lo_idata,
    output logic [31:0]        o_exe_out,
    output logic [31:0]        o_DMEM_rdata,
    output logic               mem_stall,
    pipe_mem_stage_if.master   dmem,
    output logic               dmem_err,
    output logic               exc_misalign,
    output mem_state_e         dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_req_t      req_q, req_d;
    wb_ctrl_t      wb_q, wb_d;

    wb_ctrl_t      wb_in, wb_out;
    logic [31:0]   rdata_out;
    logic          misaligned;
    logic          in_access;

    logic [1:0]    al_size;
    logic [1:0]    al_lane;
    logic          al_sext;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    assign wb_in = '{
        mux_rf_dmem: mux_rf_DMEM,
        rf_wena:     rf_wena,
        rf_waddr:    rf_waddr,
        hi_ena:      hi_ena,
        hi_idata:    hi_idata,
        lo_ena:      lo_ena,
        lo_idata:    lo_idata,
        exe_out:     exe_out
    };

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(mem_size, exe_out[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign in_access = (state_q == MEM_ACCESS);

    // Aligner sees the live slot while idle (store steering) and the captured request during access (load extraction)
    always_comb begin
        al_size = in_access ? req_q.size        : mem_size;
        al_lane = in_access ? wb_q.exe_out[1:0] : exe_out[1:0];
        al_sext = in_access ? req_q.sext        : mem_sext;
    end

    mem_align u_align (
        .size      (al_size),
        .lane      (al_lane),
        .sext      (al_sext),
        .wdata_in  (mem_wdata),
        .rdata_in  (dmem.dmem_rdata),
        .be        (al_be),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    // FSM next state, request capture, timeout count and all stage outputs
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_d           = req_q;
        wb_d            = wb_q;
        wb_out          = '0;
        rdata_out       = 32'h0;
        mem_stall       = 1'b0;
        dmem_err        = 1'b0;
        exc_misalign    = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_addr  = 32'h0;
        dmem.dmem_wdata = 32'h0;

        case (state_q)
            MEM_IDLE: begin
                if (in_valid && (mem_ren || mem_wen)) begin
                    if (misaligned) begin
                        // Trap: no access, bubble, pipe keeps moving
                        exc_misalign = 1'b1;
                    end else begin
                        req_d = '{
                            we:    mem_wen,
                            size:  mem_size,
                            sext:  mem_sext,
                            be:    al_be,
                            wdata: al_wdata
                        };
                        wb_d      = wb_in;
                        cnt_d     = '0;
                        mem_stall = 1'b1;
                        state_d   = MEM_ACCESS;
                    end
                end else begin
                    wb_out = wb_in;
                end
            end
            MEM_ACCESS: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = req_q.we;
                dmem.dmem_be    = req_q.be;
                dmem.dmem_addr  = {wb_q.exe_out[31:2], 2'b00};
                dmem.dmem_wdata = req_q.wdata;
                if (dmem.dmem_ready) begin
                    // Ready beats the timeout even on the final allowed cycle
                    wb_out    = wb_q;
                    rdata_out = al_rdata;
                    cnt_d     = '0;
                    state_d   = MEM_IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    dmem_err = 1'b1;
                    cnt_d    = '0;
                    state_d  = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            state_d        = MEM_IDLE;
            cnt_d          = '0;
            mem_stall      = 1'b0;
            dmem_err       = 1'b0;
            exc_misalign   = 1'b0;
            dmem.dmem_req  = 1'b0;
            dmem.dmem_we   = 1'b0;
            dmem.dmem_be   = 4'b0000;
            wb_out.rf_wena = 1'b0;
            wb_out.hi_ena  = 1'b0;
            wb_out.lo_ena  = 1'b0;
        end
    end

    // State, timeout counter and captured request/writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
        end
    end

    assign o_mux_rf_DMEM = wb_out.mux_rf_dmem;
    assign o_rf_wena     = wb_out.rf_wena;
    assign o_rf_waddr    = wb_out.rf_waddr;
    assign o_hi_ena      = wb_out.hi_ena;
    assign o_hi_idata    = wb_out.hi_idata;
    assign o_lo_ena      = wb_out.lo_ena;
    assign o_lo_idata    = wb_out.lo_idata;
    assign o_exe_out     = wb_out.exe_out;
    assign o_DMEM_rdata  = rdata_out;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: a transaction-level model schedules the expected
// outputs of every cycle, a memory responder serves the bus with planned
// latencies, and one compare process checks each cycle at the falling edge.
module tb_pipe_mem_stage;
    import pipe_pkg::*;

    localparam int TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        in_valid, mem_ren, mem_wen, mem_sext;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata, exe_out;
    logic        mux_rf_DMEM, rf_wena, hi_ena, lo_ena;
    logic [4:0]  rf_waddr;
    logic [31:0] hi_idata, lo_idata;
    logic        o_mux_rf_DMEM, o_rf_wena, o_hi_ena, o_lo_ena;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_hi_idata, o_lo_idata, o_exe_out, o_DMEM_rdata;
    logic        mem_stall, dmem_err, exc_misalign;
    mem_state_e  dbg_state;

    pipe_mem_stage_if dmem_bus();

    pipe_mem_stage #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .mem_size      (mem_size),
        .mem_sext      (mem_sext),
        .mem_wdata     (mem_wdata),
        .exe_out       (exe_out),
        .mux_rf_DMEM   (mux_rf_DMEM),
        .rf_wena       (rf_wena),
        .rf_waddr      (rf_waddr),
        .hi_ena        (hi_ena),
        .hi_idata      (hi_idata),
        .lo_ena        (lo_ena),
        .lo_idata      (lo_idata),
        .o_mux_rf_DMEM (o_mux_rf_DMEM),
        .o_rf_wena     (o_rf_wena),
        .o_rf_waddr    (o_rf_waddr),
        .o_hi_ena      (o_hi_ena),
        .o_hi_idata    (o_hi_idata),
        .o_lo_ena      (o_lo_ena),
        .o_lo_idata    (o_lo_idata),
        .o_exe_out     (o_exe_out),
        .o_DMEM_rdata  (o_DMEM_rdata),
        .mem_stall     (mem_stall),
        .dmem          (dmem_bus),
        .dmem_err      (dmem_err),
        .exc_misalign  (exc_misalign),
        .dbg_state     (dbg_state)
    );

    // ---------------- types ----------------
    typedef struct {
        bit          valid;
        bit          ren;
        bit          wen;
        logic [1:0]  size;
        bit          sext;
        logic [31:0] wdata;
        logic [31:0] addr;
        bit          mux;
        bit          rf_wena;
        logic [4:0]  waddr;
        bit          hi_ena;
        logic [31:0] hi;
        bit          lo_ena;
        logic [31:0] lo;
        int          lat;
    } op_t;

    typedef struct packed {
        logic        chk_wb;
        logic        chk_bus;
        logic        chk_rd;
        logic        chk_exe;
        logic        stall;
        logic        req;
        logic        err;
        logic        mis;
        logic        rf_wena;
        logic        hi_ena;
        logic        lo_ena;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exe_out;
        logic [31:0] rdata;
        logic        mux;
        logic [4:0]  waddr;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    // ---------------- scoreboard state ----------------
    exp_t        exp_q[$];
    exp_t        cur_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] dmem_arr[256];
    int          plan_lat = 0;
    int          rcnt     = 0;
    bit          trap_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Access covers the naturally aligned group of n bytes containing the address
    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] lane);
        int n   = m_nbytes(size);
        int eff = int'(lane) - (int'(lane) % n);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < 4; i++) be[i] = (i >= eff) && (i < eff + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        int n = m_nbytes(size);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sext,
                                           input logic [1:0] lane, input logic [31:0] word);
        int n   = m_nbytes(size);
        int eff = int'(lane) - (int'(lane) % n);
        logic [31:0] v = 32'h0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = word[8*(eff + j) +: 8];
        if (sext && v[8*n - 1])
            for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic bit m_trap(input logic [1:0] size, input logic [1:0] lane);
        return trap_en && ((int'(lane) % m_nbytes(size)) != 0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input op_t op);
        rst         = 1'b0;
        in_valid    = op.valid;
        mem_ren     = op.ren;
        mem_wen     = op.wen;
        mem_size    = op.size;
        mem_sext    = op.sext;
        mem_wdata   = op.wdata;
        exe_out     = op.addr;
        mux_rf_DMEM = op.mux;
        rf_wena     = op.rf_wena;
        rf_waddr    = op.waddr;
        hi_ena      = op.hi_ena;
        hi_idata    = op.hi;
        lo_ena      = op.lo_ena;
        lo_idata    = op.lo;
    endtask

    task automatic reset_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = '0;
        exp_q.push_back(e);
    endtask

    // Runs one EX/MEM slot; abort_at >= 0 stops before that ACCESS cycle
    task automatic run_op(input op_t op, input int abort_at);
        exp_t e;
        bit   is_mem;
        logic [7:0] w;
        logic [3:0] be;
        logic [31:0] wd;
        is_mem = op.valid && (op.ren || op.wen);
        be     = m_be(op.size, op.addr[1:0]);
        wd     = m_wdata(op.size, op.wdata);
        w      = op.addr[9:2];

        @(posedge clk);
        #1;
        drive(op);
        plan_lat = op.lat;
        e = '0;
        e.chk_exe = 1'b1;
        if (!is_mem) begin
            e.chk_wb  = 1'b1;
            e.rf_wena = op.rf_wena;
            e.hi_ena  = op.hi_ena;
            e.lo_ena  = op.lo_ena;
            e.exe_out = op.addr;
            e.mux     = op.mux;
            e.waddr   = op.waddr;
            e.hi      = op.hi;
            e.lo      = op.lo;
        end else if (m_trap(op.size, op.addr[1:0])) begin
            e.mis = 1'b1;
        end else begin
            e.stall = 1'b1;
        end
        exp_q.push_back(e);
        if (!is_mem || m_trap(op.size, op.addr[1:0])) return;

        for (int k = 0; k <= TIMEOUT; k++) begin
            if (k == abort_at) return;
            @(posedge clk);
            #1;
            e = '0;
            e.chk_exe = 1'b1;
            e.chk_bus = 1'b1;
            e.req     = 1'b1;
            e.we      = op.wen;
            e.be      = be;
            e.addr    = {op.addr[31:2], 2'b00};
            e.wdata   = wd;
            if (k == op.lat) begin
                e.chk_wb  = 1'b1;
                e.rf_wena = op.rf_wena;
                e.hi_ena  = op.hi_ena;
                e.lo_ena  = op.lo_ena;
                e.exe_out = op.addr;
                e.mux     = op.mux;
                e.waddr   = op.waddr;
                e.hi      = op.hi;
                e.lo      = op.lo;
                if (op.ren) begin
                    e.chk_rd = 1'b1;
                    e.rdata  = m_load(op.size, op.sext, op.addr[1:0], ref_mem[w]);
                end
                if (op.wen)
                    for (int i = 0; i < 4; i++)
                        if (be[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
                exp_q.push_back(e);
                break;
            end else if (k == TIMEOUT) begin
                e.err = 1'b1;
                exp_q.push_back(e);
                break;
            end else begin
                e.stall = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic op_t mk_op(input bit valid, input bit ren, input bit wen,
                                  input logic [1:0] size, input bit sext,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit rf_we, input int lat);
        op_t op;
        op.valid   = valid;
        op.ren     = ren;
        op.wen     = wen;
        op.size    = size;
        op.sext    = sext;
        op.addr    = addr;
        op.wdata   = wdata;
        op.mux     = ren;
        op.rf_wena = rf_we;
        op.waddr   = 5'($urandom_range(1, 31));
        op.hi_ena  = 1'b0;
        op.hi      = $urandom;
        op.lo_ena  = 1'b0;
        op.lo      = $urandom;
        op.lat     = lat;
        return op;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        int  kind = $urandom_range(0, 9);
        op.valid   = 1'b1;
        op.ren     = 1'b0;
        op.wen     = 1'b0;
        op.size    = 2'($urandom_range(0, 2));
        op.sext    = 1'($urandom_range(0, 1));
        op.addr    = 32'h100 + 32'($urandom_range(0, 63));
        op.wdata   = $urandom;
        op.mux     = 1'($urandom_range(0, 1));
        op.rf_wena = 1'($urandom_range(0, 1));
        op.waddr   = 5'($urandom_range(0, 31));
        op.hi_ena  = 1'($urandom_range(0, 1));
        op.hi      = $urandom;
        op.lo_ena  = 1'($urandom_range(0, 1));
        op.lo      = $urandom;
        op.lat     = $urandom_range(0, 6);
        if (kind <= 1) begin
            op.addr = $urandom;
        end else if (kind == 2) begin
            op.valid = 1'b0;
            op.ren   = 1'($urandom_range(0, 1));
            op.wen   = ~op.ren;
        end else if (kind <= 6) begin
            op.ren = 1'b1;
        end else begin
            op.wen     = 1'b1;
            op.rf_wena = 1'b0;
        end
        return op;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (dmem_bus.dmem_req === 1'b1) begin
                dmem_bus.dmem_ready = (rcnt == plan_lat);
                dmem_bus.dmem_rdata = (rcnt == plan_lat) ? dmem_arr[dmem_bus.dmem_addr[9:2]] : $urandom;
                rcnt++;
            end else begin
                rcnt = 0;
                dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
                dmem_bus.dmem_rdata = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (dmem_bus.dmem_req === 1'b1 && dmem_bus.dmem_ready && dmem_bus.dmem_we)
            for (int i = 0; i < 4; i++)
                if (dmem_bus.dmem_be[i])
                    dmem_arr[dmem_bus.dmem_addr[9:2]][8*i +: 8] = dmem_bus.dmem_wdata[8*i +: 8];
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            chk("mem_stall",    32'(mem_stall),    32'(cur_e.stall));
            chk("dmem_req",     32'(dmem_bus.dmem_req), 32'(cur_e.req));
            chk("dmem_err",     32'(dmem_err),     32'(cur_e.err));
            chk("exc_misalign", 32'(exc_misalign), 32'(cur_e.mis));
            chk("o_rf_wena",    32'(o_rf_wena),    32'(cur_e.rf_wena));
            chk("o_hi_ena",     32'(o_hi_ena),     32'(cur_e.hi_ena));
            chk("o_lo_ena",     32'(o_lo_ena),     32'(cur_e.lo_ena));
            if (cur_e.chk_exe) chk("o_exe_out", o_exe_out, cur_e.exe_out);
            if (cur_e.chk_bus) begin
                chk("dmem_we",   32'(dmem_bus.dmem_we), 32'(cur_e.we));
                chk("dmem_be",   32'(dmem_bus.dmem_be), 32'(cur_e.be));
                chk("dmem_addr", dmem_bus.dmem_addr,    cur_e.addr);
                if (cur_e.we) chk("dmem_wdata", dmem_bus.dmem_wdata, cur_e.wdata);
            end
            if (cur_e.chk_rd) chk("o_DMEM_rdata", o_DMEM_rdata, cur_e.rdata);
            if (cur_e.chk_wb) begin
                chk("o_mux_rf_DMEM", 32'(o_mux_rf_DMEM), 32'(cur_e.mux));
                chk("o_rf_waddr",    32'(o_rf_waddr),    32'(cur_e.waddr));
                chk("o_hi_idata",    o_hi_idata,         cur_e.hi);
                chk("o_lo_idata",    o_lo_idata,         cur_e.lo);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        op_t op;
`ifdef MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        rst = 1'b1;
        drive(mk_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 0));
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = $urandom;
            dmem_arr[i] = ref_mem[i];
        end
        ref_mem[8'h40]  = 32'h80112233;
        dmem_arr[8'h40] = 32'h80112233;

        // Literal pins on the model
        chk("pin_lb_sext",  m_load(2'b00, 1'b1, 2'd3, 32'h80112233), 32'hFFFFFF80);
        chk("pin_lhu",      m_load(2'b01, 1'b0, 2'd2, 32'h80112233), 32'h00008011);
        chk("pin_sh_be",    32'(m_be(2'b01, 2'd2)),                  32'h0000000C);
        chk("pin_sh_wdata", m_wdata(2'b01, 32'h0000ABCD),            32'hABCDABCD);
        chk("pin_sb_wdata", m_wdata(2'b00, 32'h123456F7),            32'hF7F7F7F7);
        chk("pin_lw_be",    32'(m_be(2'b10, 2'd1)),                  32'h0000000F);

        @(posedge clk);
        repeat (3) reset_cycle();
        @(negedge clk);
        #1;
        chk("dbg_state_after_reset", 32'(dbg_state), 32'(MEM_IDLE));

        // ALU op passes through with zero latency
        op = mk_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1, 0);
        run_op(op, -1);
        // lb 0x103 sign-extended, ready after 3 ACCESS cycles
        run_op(mk_op(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 3), -1);
        // sh 0x202, ready immediately
        run_op(mk_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 1'b0, 0), -1);
        // lw never ready -> timeout, then the next op proceeds
        run_op(mk_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1, 99), -1);
        run_op(mk_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h5678, 32'h0, 1'b1, 0), -1);
        // lw ready exactly on the timeout cycle
        run_op(mk_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 1'b1, TIMEOUT), -1);
        // misaligned lw
        run_op(mk_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 1), -1);
        // reset during the second ACCESS cycle
        run_op(mk_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 1'b1, 99), 1);
        repeat (2) reset_cycle();
        run_op(mk_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 0), -1);
        @(negedge clk);
        #1;
        chk("dbg_state_after_mid_reset", 32'(dbg_state), 32'(MEM_IDLE));

        // Randomized traffic
        for (int n = 0; n < 400; n++) run_op(rand_op(), -1);

        run_op(mk_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 0), -1);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
